// File: rtl/dbg_exec_pkg.sv
// Shared encodings for the debug execution controller: commands, FSM states
// and stop causes reported back to the debug unit.
package dbg_exec_pkg;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_RUN     = 3'd1,
    CMD_STEP    = 3'd2,
    CMD_PAUSE   = 3'd3,
    CMD_CLR_CNT = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_STEP = 2'd1,
    CAUSE_BKPT = 2'd2,
    CAUSE_STOP = 2'd3
  } cause_e;

  // Slot index width; a single slot still needs a 1-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dbg_exec_controller_bkpt_match.sv
// PC breakpoint slots: per-slot address/enable registers with a write port
// and a parallel comparator OR-reduced into a single hit.
module bkpt_match
  import dbg_exec_pkg::*;
#(
  parameter int DWORD  = 32,
  parameter int N_BKPT = 4,
  parameter int IDX_W  = idx_w(N_BKPT)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_wr,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [DWORD-1:0] i_addr,
  input  logic             i_en,
  input  logic [DWORD-1:0] i_pc,
  output logic             o_hit
);

  logic [N_BKPT-1:0] match;

  for (genvar g = 0; g < N_BKPT; g++) begin : g_slot
    logic [DWORD-1:0] addr_q, addr_d;
    logic             en_q, en_d;

    always_comb begin
      addr_d = addr_q;
      en_d   = en_q;
      if (i_wr && (i_idx == IDX_W'(g))) begin
        addr_d = i_addr;
        en_d   = i_en;
      end
    end

    always_ff @(posedge i_clock) begin
      if (!i_reset) begin
        addr_q <= '0;
        en_q   <= 1'b0;
      end else begin
        addr_q <= addr_d;
        en_q   <= en_d;
      end
    end

    assign match[g] = en_q && (addr_q == i_pc);
  end

  assign o_hit = |match;

endmodule

// File: rtl/dbg_exec_controller.sv
// Debug execution controller: turns debug-unit commands into a data-path
// clock enable with run/step/pause, PC breakpoints, HALT latching and a cycle counter.
module dbg_exec_controller
  import dbg_exec_pkg::*;
#(
  parameter int DWORD  = 32,
  parameter int N_BKPT = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_cmd_valid,
  input  logic [2:0]                i_cmd,
  input  logic [CNT_W-1:0]          i_cmd_count,
  input  logic                      i_bkpt_wr,
  input  logic [idx_w(N_BKPT)-1:0]  i_bkpt_idx,
  input  logic [DWORD-1:0]          i_bkpt_addr,
  input  logic                      i_bkpt_en,
  input  logic                      i_hlt,
  input  logic [DWORD-1:0]          i_pc_value,
  output logic                      o_dp_enable,
  output logic                      o_cmd_ready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [1:0]                o_stop_cause,
  output logic                      o_paused,
  output logic [DWORD-1:0]          o_cycle_count
);

  state_e           state_q, state_d;
  cause_e           cause_q, cause_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DWORD-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             paused_q, paused_d;

  logic bp_hit, busy, cmd_acc, hit_hlt, hit_bp, dp_en, pause, exhaust, stop;

  bkpt_match #(.DWORD(DWORD), .N_BKPT(N_BKPT)) u_bkpt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_wr    (i_bkpt_wr),
    .i_idx   (i_bkpt_idx),
    .i_addr  (i_bkpt_addr),
    .i_en    (i_bkpt_en),
    .i_pc    (i_pc_value),
    .o_hit   (bp_hit)
  );

  assign busy    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign cmd_acc = i_cmd_valid && (state_q != ST_HALTED);
  assign hit_hlt = busy && i_hlt;
  // The first busy cycle ignores breakpoints so a run can leave a breakpoint PC.
  assign hit_bp  = busy && bp_hit && !first_q;
  assign dp_en   = busy && !hit_hlt && !hit_bp;
  assign pause   = busy && cmd_acc && (i_cmd == CMD_PAUSE);
  assign exhaust = (state_q == ST_STEP) && dp_en && (rem_q == CNT_W'(1));
  assign stop    = hit_hlt || hit_bp || pause || exhaust;

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    paused_d = paused_q;
    first_d  = busy ? 1'b0 : first_q;
    rem_d    = rem_q;
    done_d   = stop;

    case (state_q)
      ST_IDLE: begin
        if (cmd_acc && (i_cmd == CMD_RUN)) begin
          state_d = ST_RUN;
          first_d = 1'b1;
        end else if (cmd_acc && (i_cmd == CMD_STEP)) begin
          state_d = ST_STEP;
          first_d = 1'b1;
          rem_d   = (i_cmd_count == '0) ? CNT_W'(1) : i_cmd_count;
        end
      end
      ST_RUN, ST_STEP: begin
        if ((state_q == ST_STEP) && dp_en) rem_d = rem_q - CNT_W'(1);
        if (hit_hlt) begin
          state_d  = ST_HALTED;
          cause_d  = CAUSE_STOP;
          paused_d = 1'b0;
        end else if (hit_bp) begin
          state_d  = ST_IDLE;
          cause_d  = CAUSE_BKPT;
          paused_d = 1'b0;
        end else if (pause) begin
          state_d  = ST_IDLE;
          cause_d  = CAUSE_STOP;
          paused_d = 1'b1;
        end else if (exhaust) begin
          state_d  = ST_IDLE;
          cause_d  = CAUSE_STEP;
          paused_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Clear beats increment; a stop in the same cycle drops the clear command.
    cnt_d = cnt_q;
    if (cmd_acc && (i_cmd == CMD_CLR_CNT) && !stop) cnt_d = '0;
    else if (dp_en && !(&cnt_q))                    cnt_d = cnt_q + DWORD'(1);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      cause_q  <= CAUSE_NONE;
      paused_q <= 1'b0;
      first_q  <= 1'b0;
      rem_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      paused_q <= paused_d;
      first_q  <= first_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign o_dp_enable   = dp_en;
  assign o_cmd_ready   = (state_q != ST_HALTED);
  assign o_busy        = busy;
  assign o_done        = done_q;
  assign o_stop_cause  = cause_q;
  assign o_paused      = paused_q;
  assign o_cycle_count = cnt_q;

endmodule
